// File: rtl/mdu_seq.sv
// Sequential RISC-V M-extension unit: XLEN-cycle shift-add multiply and restoring divide.
// Define MDU_EARLY_OUT_EN to let divide-by-zero and signed overflow skip the iterative phase.
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_f3;
    logic              r_neg;
    logic [XLEN-1:0]   r_m;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_last;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic              w_b_zero;
    logic              w_neg;
    logic              w_early;
    logic [XLEN-1:0]   w_ma;
    logic [XLEN-1:0]   w_mb;
    logic [XLEN:0]     w_sum;
    logic              w_rem_ge;
    logic [XLEN-1:0]   w_diff;
    logic [XLEN-1:0]   w_step_hi;
    logic [XLEN-1:0]   w_step_lo;
`ifdef MDU_EARLY_OUT_EN
    logic              w_ovf;
    logic [XLEN-1:0]   w_early_res;
`endif

    function automatic logic [XLEN-1:0] f_abs(input logic [XLEN-1:0] v, input logic s);
        return s ? -v : v;
    endfunction

    // Sign correction and result selection on the final accumulator contents.
    function automatic logic [XLEN-1:0] f_finalize(
        input logic [2:0]      f3,
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo,
        input logic            neg
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   res;
        prod = neg ? -{hi, lo} : {hi, lo};
        case (f3)
            3'b000:                 res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res = neg ? -lo : lo;
            default:                res = neg ? -hi : hi;
        endcase
        return res;
    endfunction

`ifdef MDU_EARLY_OUT_EN
    function automatic logic [XLEN-1:0] f_early(
        input logic            is_rem,
        input logic            b_zero,
        input logic [XLEN-1:0] a
    );
        if (b_zero)
            return is_rem ? a : '1;
        return is_rem ? '0 : a;
    endfunction
`endif

    // Request decode: operand signedness, magnitudes and result sign.
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            3'b010:  w_a_signed = 1'b1;
            default: ;
        endcase
        w_sa     = w_a_signed & op_a[XLEN-1];
        w_sb     = w_b_signed & op_b[XLEN-1];
        w_ma     = f_abs(op_a, w_sa);
        w_mb     = f_abs(op_b, w_sb);
        w_b_zero = (op_b == '0);
        if (!funct3[2])
            w_neg = w_sa ^ w_sb;
        else if (!funct3[1])
            w_neg = (w_sa ^ w_sb) & ~w_b_zero;
        else
            w_neg = w_sa;
    end

`ifdef MDU_EARLY_OUT_EN
    assign w_ovf       = w_a_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign w_early     = funct3[2] && (w_b_zero || w_ovf);
    assign w_early_res = f_early(funct3[1], w_b_zero, op_a);
`else
    assign w_early     = 1'b0;
`endif

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
        w_rem_ge = ({r_hi, r_lo[XLEN-1]} >= {1'b0, r_m});
        w_diff   = {r_hi[XLEN-2:0], r_lo[XLEN-1]} - r_m;
        if (r_f3[2]) begin
            w_step_hi = w_rem_ge ? w_diff : {r_hi[XLEN-2:0], r_lo[XLEN-1]};
            w_step_lo = {r_lo[XLEN-2:0], w_rem_ge};
        end else begin
            w_step_hi = w_sum[XLEN:1];
            w_step_lo = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_state == S_CALC) && (r_cnt == CNT_W'(XLEN-1));

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = w_early ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush)
                    w_next_state = S_IDLE;
                else if (w_last)
                    w_next_state = S_DONE;
            end
            S_DONE: if (flush || out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE) && !flush;
        busy      = (r_state != S_IDLE);
        out_valid = (r_state == S_DONE);
        result    = out_valid ? r_result : '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_accept)
            r_cnt <= '0;
        else if (r_state == S_CALC)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    // Datapath: multiplier in r_lo / multiplicand in r_m; dividend in r_lo / divisor in r_m.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_f3  <= funct3;
            r_neg <= w_neg;
            r_hi  <= '0;
            if (funct3[2]) begin
                r_m  <= w_mb;
                r_lo <= w_ma;
            end else begin
                r_m  <= w_ma;
                r_lo <= w_mb;
            end
`ifdef MDU_EARLY_OUT_EN
            r_result <= w_early_res;
`endif
        end else if (r_state == S_CALC) begin
            r_hi <= w_step_hi;
            r_lo <= w_step_lo;
            if (w_last)
                r_result <= f_finalize(r_f3, w_step_hi, w_step_lo, r_neg);
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: directed vectors, monitor compares on every valid output cycle.
module tb_mdu_seq;

    localparam int LAT = 33;
`ifdef MDU_EARLY_OUT_EN
    localparam int LAT_EARLY = 1;
`else
    localparam int LAT_EARLY = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    mdu_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          first;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   hs_cyc = -1;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compares every valid output cycle against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check_bit("unexpected_out_valid", out_valid, 1'b0);
                end else begin
                    if (!prev_valid)
                        check({"latency ", sb_q[0].tag}, 32'(cyc), 32'(sb_q[0].first));
                    check({"result ", sb_q[0].tag}, result, sb_q[0].res);
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        hs_cyc = cyc;
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat, input bit push,
                         input string tag, output int k);
        @(posedge clk); #1;
        in_valid = 1'b1;
        funct3   = f;
        op_a     = a;
        op_b     = b;
        k = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                k = cyc;
                break;
            end
        end
        if (k < 0)
            check_bit({"accept_timeout ", tag}, 1'b0, 1'b1);
        else if (push)
            sb_q.push_back('{res: e, first: k + lat, tag: tag});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            check_bit({"result_timeout ", tag}, 1'b0, 1'b1);
            sb_q.delete();
        end
    endtask

    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen)
            check_bit({"valid_timeout ", tag}, 1'b0, 1'b1);
    endtask

    task automatic run_vec(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e, input bit early, input string tag);
        int k;
        issue(f, a, b, e, early ? LAT_EARLY : LAT, 1'b1, tag, k);
        wait_idle(tag);
    endtask

    initial begin
        int k;
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        funct3    = 3'b000;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_bit("reset in_ready", in_ready, 1'b1);
        check_bit("reset busy", busy, 1'b0);
        check_bit("reset out_valid", out_valid, 1'b0);
        check("reset result", result, 32'h0);

        // MUL 7 * -3 with busy window
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT, 1'b1, "MUL_7x-3", k);
        @(negedge clk);
        check_bit("busy at k+1", busy, 1'b1);
        repeat (32) @(negedge clk);
        check("cycle at k+33", 32'(cyc), 32'(k + 33));
        check_bit("busy at k+33", busy, 1'b1);
        check_bit("out_valid at k+33", out_valid, 1'b1);
        @(negedge clk);
        check_bit("busy at k+34", busy, 1'b0);
        check_bit("in_ready at k+34", in_ready, 1'b1);
        wait_idle("MUL_7x-3");

        run_vec(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "MULH_min");
        run_vec(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "MULHU_max");
        run_vec(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "MULHSU");
        run_vec(3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0, "MUL_shift");
        run_vec(3'b011, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 1'b0, "MULHU_shift");
        run_vec(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "DIV_-7/2");
        run_vec(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "REM_-7/2");
        run_vec(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "DIV_7/-2");
        run_vec(3'b110, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "REM_7/-2");
        run_vec(3'b101, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 1'b0, "DIVU_max/3");
        run_vec(3'b111, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 1'b0, "REMU_max/16");
        run_vec(3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b1, "DIVU_7/0");
        run_vec(3'b111, 32'd7, 32'd0, 32'h0000_0007, 1'b1, "REMU_7/0");
        run_vec(3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b1, "DIV_-7/0");
        run_vec(3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1, "REM_-7/0");
        run_vec(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "DIV_ovf");
        run_vec(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "REM_ovf");
        run_vec(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "DIVU_noovf");

        // Stall in DONE, then back-to-back accept after the handshake
        out_ready = 1'b0;
        issue(3'b101, 32'd100, 32'd7, 32'd14, LAT, 1'b1, "DIVU_stall", k);
        wait_valid("DIVU_stall");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_bit("stall out_valid", out_valid, 1'b1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        funct3    = 3'b111;
        op_a      = 32'd100;
        op_b      = 32'd7;
        @(negedge clk);
        check_bit("in_ready in handshake", in_ready, 1'b0);
        issue(3'b111, 32'd100, 32'd7, 32'd2, LAT, 1'b1, "REMU_b2b", k);
        check("b2b accept cycle", 32'(k), 32'(hs_cyc + 1));
        wait_idle("REMU_b2b");

        // Flush at counter 10
        issue(3'b000, 32'd5, 32'd6, 32'd30, LAT, 1'b0, "MUL_flushed", k);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check_bit("busy at flush", busy, 1'b1);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check_bit("busy after flush", busy, 1'b0);
        check_bit("in_ready after flush", in_ready, 1'b1);
        check_bit("out_valid after flush", out_valid, 1'b0);
        repeat (40) @(negedge clk);

        // Flush in IDLE with a request present
        @(posedge clk); #1;
        in_valid = 1'b1;
        flush    = 1'b1;
        funct3   = 3'b000;
        op_a     = 32'd3;
        op_b     = 32'd3;
        @(negedge clk);
        check_bit("in_ready under flush", in_ready, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check_bit("busy after flushed request", busy, 1'b0);

        // Reset while holding a result in DONE
        out_ready = 1'b0;
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, 1'b1, "MULHU_rst", k);
        wait_valid("MULHU_rst");
        @(posedge clk);
        #1 rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_bit("rst out_valid", out_valid, 1'b0);
        check("rst result", result, 32'h0);
        check_bit("rst busy", busy, 1'b0);
        check_bit("rst in_ready", in_ready, 1'b1);

        run_vec(3'b100, 32'd100, 32'd7, 32'd14, 1'b0, "DIV_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter XLEN, default 32, operand and result width.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  request present.
REQ-005 in_ready  out  1  unit can accept a request.
REQ-006 funct3  in  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 op_a  in  XLEN  rs1 value.
REQ-008 op_b  in  XLEN  rs2 value.
REQ-009 flush  in  1  pipeline kill; abandons any in-flight op.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer takes the result.
REQ-012 result  out  XLEN  operation result.
REQ-013 busy  out  1  high in every state except IDLE; drives the pipeline stall.

Function
REQ-014 FSM states IDLE, CALC, DONE; in_ready = (state==IDLE) && !flush.
REQ-015 Accept on in_valid && in_ready in cycle k: latch funct3, operand magnitudes, result-sign flags; go CALC with counter=0 at k+1.
REQ-016 CALC runs exactly XLEN cycles (counter 0..XLEN-1); multiply is one shift-add step per cycle, divide is one restoring step per cycle.
REQ-017 Last CALC cycle: apply sign correction, register result, enter DONE; out_valid first high at cycle k+XLEN+1.
REQ-018 Signed ops use magnitudes internally. MULH: both signed. MULHSU: op_a signed, op_b unsigned. MUL returns low XLEN bits of the 2*XLEN product; MULH/MULHSU/MULHU return high XLEN bits.
REQ-019 DIV/REM truncate toward zero; remainder takes the sign of the dividend.
REQ-020 Divide by zero: quotient all-ones; remainder = op_a, for signed and unsigned ops.
REQ-021 Signed overflow (op_a = -2^(XLEN-1), op_b = -1): DIV returns -2^(XLEN-1); REM returns 0.
REQ-022 DONE: out_valid and result held stable until out_ready; out_valid && out_ready returns to IDLE next cycle.
REQ-023 No accept in the handshake cycle (in_ready low in DONE); earliest back-to-back accept is the cycle after the handshake.
REQ-024 flush in any state: IDLE next cycle, out_valid low, no result delivered; flush overrides in_valid and out_ready in the same cycle.
REQ-025 result = 0 whenever out_valid is low.

Reset
REQ-026 rst overrides all inputs, including mid-CALC and in DONE, and aborts any op silently.
REQ-027 Reset values: state IDLE, counter 0, out_valid 0, result 0, busy 0. in_ready is 1 in the first cycle after reset release.

Configuration
REQ-028 Macro MDU_EARLY_OUT_EN.
REQ-029 Defined: divide-by-zero and signed-overflow requests skip CALC, go IDLE->DONE; out_valid at k+1 with REQ-020/021 results.
REQ-030 Not defined: those cases run the full XLEN-cycle CALC with the same results and latency as any divide.
REQ-031 Results are bit-identical with and without the macro; only latency differs.

Verification
REQ-032 MUL op_a=7, op_b=-3 (0xFFFFFFFD), out_ready=1 -> result 0xFFFFFFEB, out_valid at k+33, busy high k+1..k+33.
REQ-033 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000, out_valid at k+1 with MDU_EARLY_OUT_EN, k+33 without.
REQ-035 DONE with out_ready low for 5 cycles -> out_valid and result stable; raise out_ready -> IDLE next cycle, next request accepted the cycle after.
REQ-036 flush at CALC counter=10 -> IDLE next cycle, out_valid never high; flush with in_valid in IDLE -> request not accepted.
REQ-037 rst in DONE with out_valid high -> next cycle out_valid 0, result 0, busy 0, in_ready 1.
